idex_stage: RTL

ID/EX pipeline register of the RISC-V AXI core, with load-use hazard detection and write-back bypass on operand capture. Sits between decode and execute. Its registered `idex_rs1`, `idex_rs2`, `idex_wb` and `idex_rd` outputs are the EX-side inputs to the forwarding unit and the pipeline's later stages. It converts stalls, flushes and load-use hazards into held instructions or inserted bubbles, and counts the bubbles it inserts.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/idex_stage_if.sv | 53 +++++
 rtl/load_use_detect.sv | 20 ++
 rtl/idex_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types for the decode/execute boundary.
//   alu_op_e : ALU operation encodings carried in ctrl_t.alu_op
//   ctrl_t   : decoded control bundle travelling with each instruction
//   CTRL_NOP : all-zero control word (bubble / invalid instruction)
//   REG_X0   : index of the hard-wired zero register
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // alu_op kept as raw bits so the whole word can be zeroed with '0.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       wb;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] REG_X0   = 5'd0;

endpackage

// File: rtl/idex_stage_if.sv
// Bundle of all ID/EX stage signals except clk/rst.
//   master : the decode / write-back / pipeline-control side (drives id_*, wb_*,
//            mem_stall, flush; observes idex_*, id_stall, bubble_cnt)
//   slave  : the idex_stage register itself
interface idex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import riscv_pkg::*;

  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  ctrl_t            id_ctrl;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             mem_stall;
  logic             flush;

  logic             idex_valid;
  logic [XLEN-1:0]  idex_pc;
  logic [XLEN-1:0]  idex_imm;
  logic [XLEN-1:0]  idex_rs1_data;
  logic [XLEN-1:0]  idex_rs2_data;
  logic [4:0]       idex_rs1;
  logic [4:0]       idex_rs2;
  logic [4:0]       idex_rd;
  ctrl_t            idex_ctrl;
  logic             idex_wb;
  logic             id_stall;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_ctrl, wb_we, wb_rd, wb_data, mem_stall, flush,
    input  idex_valid, idex_pc, idex_imm, idex_rs1_data, idex_rs2_data,
           idex_rs1, idex_rs2, idex_rd, idex_ctrl, idex_wb, id_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_ctrl, wb_we, wb_rd, wb_data, mem_stall, flush,
    output idex_valid, idex_pc, idex_imm, idex_rs1_data, idex_rs2_data,
           idex_rs1, idex_rs2, idex_rd, idex_ctrl, idex_wb, id_stall, bubble_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   idex_valid_i, mem_read_i, idex_rd_i : instruction currently in EX
//   id_valid_i, id_rs1_i, id_rs2_i      : instruction currently in ID
//   lu_hz_o                             : ID consumes the result of a load in EX
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       idex_valid_i,
  input  logic       mem_read_i,
  input  logic [4:0] idex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       lu_hz_o
);

  assign lu_hz_o = idex_valid_i & mem_read_i & (idex_rd_i != REG_X0) & id_valid_i &
                   ((id_rs1_i == idex_rd_i) | (id_rs2_i == idex_rd_i));

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, write-back bypass on
// operand capture and a saturating bubble counter.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : idex_stage_if slave (ID inputs, WB bypass, stall/flush, EX outputs)
// Edge priority: mem_stall hold > flush bubble > load-use bubble (counted) > load.
module idex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  idex_stage_if.slave  bus
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu_hz;
  logic byp_rs1;
  logic byp_rs2;

  load_use_detect u_lud (
    .idex_valid_i (valid_q),
    .mem_read_i   (ctrl_q.mem_read),
    .idex_rd_i    (rd_q),
    .id_valid_i   (bus.id_valid),
    .id_rs1_i     (bus.id_rs1),
    .id_rs2_i     (bus.id_rs2),
    .lu_hz_o      (lu_hz)
  );

  assign byp_rs1 = bus.wb_we & (bus.wb_rd != REG_X0) & (bus.wb_rd == bus.id_rs1);
  assign byp_rs2 = bus.wb_we & (bus.wb_rd != REG_X0) & (bus.wb_rd == bus.id_rs2);

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;

    if (bus.mem_stall) begin
      // whole pipeline frozen; a pending flush is applied once the stall clears
    end else if (bus.flush || lu_hz) begin
      // bubble: kill control and indices, leave data fields as they were
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      rs1_d   = REG_X0;
      rs2_d   = REG_X0;
      rd_d    = REG_X0;
      if (!bus.flush && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end else begin
      valid_d    = bus.id_valid;
      pc_d       = bus.id_pc;
      imm_d      = bus.id_imm;
      rs1_d      = bus.id_rs1;
      rs2_d      = bus.id_rs2;
      rd_d       = bus.id_rd;
      ctrl_d     = bus.id_valid ? bus.id_ctrl : CTRL_NOP;
      rs1_data_d = byp_rs1 ? bus.wb_data : bus.id_rs1_data;
      rs2_data_d = byp_rs2 ? bus.wb_data : bus.id_rs2_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= CTRL_NOP;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.idex_valid    = valid_q;
  assign bus.idex_pc       = pc_q;
  assign bus.idex_imm      = imm_q;
  assign bus.idex_rs1_data = rs1_data_q;
  assign bus.idex_rs2_data = rs2_data_q;
  assign bus.idex_rs1      = rs1_q;
  assign bus.idex_rs2      = rs2_q;
  assign bus.idex_rd       = rd_q;
  assign bus.idex_ctrl     = ctrl_q;
  assign bus.idex_wb       = ctrl_q.wb;
  assign bus.id_stall      = lu_hz | bus.mem_stall;
  assign bus.bubble_cnt    = cnt_q;

endmodule
